// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch squash and multiply/divide
// occupancy stalls, plus a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        ID_Jump,
    input  logic        ID_MD_start,
    input  logic        ID_MD_is_div,
    input  logic        ID_MD_read,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        EX_Branch_taken,
    output logic        PC_wr_en,
    output logic        IF_ID_wr_en,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        MD_busy,
    output logic        MD_done,
    output logic [15:0] stall_count
);

    localparam int unsigned STALL_W = 16;
    localparam logic [CNT_W-1:0]   MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               md_busy_q, md_done_q, md_done_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               load_use, md_haz, md_accept;

    // Hazard detection against the instruction currently in ID
    always_comb begin
        load_use = EX_MemRead && (EX_rt != 5'd0) &&
                   ((ID_uses_rs && (EX_rt == ID_rs)) ||
                    (ID_uses_rt && (EX_rt == ID_rt)));
        md_haz   = (state_q == BUSY) && (ID_MD_read || ID_MD_start);
        // A squashed ID instruction must not start the unit
        md_accept = ID_MD_start && !EX_Branch_taken && !load_use;
    end

    // Pipeline control, zero latency, priority branch > load-use > md > jump
    always_comb begin
        PC_wr_en    = 1'b1;
        IF_ID_wr_en = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        if (!reset) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (EX_Branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use || md_haz) begin
            PC_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (ID_Jump) begin
            IF_ID_flush = 1'b1;
        end
    end

    // Multiply/divide occupancy next-state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_done_d = 1'b0;
        case (state_q)
            RUN: begin
                if (md_accept) begin
                    state_d = BUSY;
                    cnt_d   = ID_MD_is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d   = RUN;
                    md_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_wr_en && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            md_busy_q   <= 1'b0;
            md_done_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            md_busy_q   <= (state_d == BUSY);
            md_done_q   <= md_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign MD_busy     = md_busy_q;
    assign MD_done     = md_done_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        ID_uses_rs, ID_uses_rt, ID_Jump, ID_MD_start, ID_MD_is_div, ID_MD_read;
    logic        EX_MemRead, EX_Branch_taken;
    logic        PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush, MD_busy, MD_done;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_stall_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
        .ID_Jump(ID_Jump), .ID_MD_start(ID_MD_start), .ID_MD_is_div(ID_MD_is_div),
        .ID_MD_read(ID_MD_read), .EX_MemRead(EX_MemRead), .EX_rt(EX_rt),
        .EX_Branch_taken(EX_Branch_taken),
        .PC_wr_en(PC_wr_en), .IF_ID_wr_en(IF_ID_wr_en), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .MD_busy(MD_busy), .MD_done(MD_done),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ID_rs = '0; ID_rt = '0; EX_rt = '0;
        ID_uses_rs = 0; ID_uses_rt = 0; ID_Jump = 0; ID_MD_start = 0;
        ID_MD_is_div = 0; ID_MD_read = 0; EX_MemRead = 0; EX_Branch_taken = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush}
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check_eq(tag, {28'd0, PC_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_flush}, {28'd0, exp});
    endtask

    initial begin
        int base;
        reset = 1'b0;
        clear_inputs();
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            {ID_rs, ID_rt, EX_rt} = 15'($urandom);
            {ID_uses_rs, ID_uses_rt, ID_Jump, ID_MD_start, ID_MD_is_div,
             ID_MD_read, EX_MemRead, EX_Branch_taken} = 8'($urandom);
            #1;
            check_ctl("rst_ctl", 4'b0011);
            check_eq("rst_busy", MD_busy, 0);
            check_eq("rst_stall", stall_count, 0);
            step();
        end
        clear_inputs();
        reset = 1'b1;
        #1;
        check_ctl("run_ctl", 4'b1100);
        step();
        check_eq("run_stall", stall_count, 0);

        // Load-use on rs
        EX_MemRead = 1; EX_rt = 5; ID_rs = 5; ID_uses_rs = 1;
        #1;
        check_ctl("lu_rs_ctl", 4'b0001);
        step();
        clear_inputs();
        #1;
        check_eq("lu_rs_stall", stall_count, 1);
        check_ctl("lu_rs_after", 4'b1100);
        // r0 never hazards
        EX_MemRead = 1; EX_rt = 0; ID_rs = 0; ID_uses_rs = 1;
        #1;
        check_ctl("lu_r0_ctl", 4'b1100);
        step();
        check_eq("lu_r0_stall", stall_count, 1);
        // Load-use on rt, then same register but rt not read
        clear_inputs();
        EX_MemRead = 1; EX_rt = 7; ID_rt = 7; ID_uses_rt = 1;
        #1;
        check_ctl("lu_rt_ctl", 4'b0001);
        ID_uses_rt = 0;
        #1;
        check_ctl("lu_rt_unused", 4'b1100);
        ID_uses_rt = 1;
        step();
        check_eq("lu_rt_stall", stall_count, 2);

        // Branch beats load-use and md start
        EX_Branch_taken = 1; ID_MD_start = 1;
        #1;
        check_ctl("br_ctl", 4'b1111);
        step();
        clear_inputs();
        #1;
        check_eq("br_busy", MD_busy, 0);
        check_eq("br_stall", stall_count, 2);

        // Jump
        ID_Jump = 1;
        #1;
        check_ctl("jmp_ctl", 4'b1110);
        step();
        clear_inputs();

        // Multiply then mflo
        base = 2;
        ID_MD_start = 1; ID_MD_is_div = 0;
        #1;
        check_ctl("mul_acc_ctl", 4'b1100);
        step();
        ID_MD_start = 0; ID_MD_read = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("mul_busy", MD_busy, 1);
            check_eq("mul_done_lo", MD_done, 0);
            check_ctl("mul_stall_ctl", 4'b0001);
            step();
        end
        check_eq("mul_busy_end", MD_busy, 0);
        check_eq("mul_done", MD_done, 1);
        check_ctl("mul_read_ctl", 4'b1100);
        check_eq("mul_stall_cnt", stall_count, 32'(base + 4));
        step();
        clear_inputs();
        #1;
        check_eq("mul_done_pulse", MD_done, 0);
        base = base + 4;

        // Back-to-back divides
        ID_MD_start = 1; ID_MD_is_div = 1;
        #1;
        check_ctl("div_acc_ctl", 4'b1100);
        step();
        for (int i = 0; i < 32; i++) begin
            check_eq("div_busy", MD_busy, 1);
            check_ctl("div_stall_ctl", 4'b0001);
            step();
        end
        check_eq("div_done", MD_done, 1);
        check_eq("div_busy_end", MD_busy, 0);
        check_ctl("div2_acc_ctl", 4'b1100);
        check_eq("div_stall_cnt", stall_count, 32'(base + 32));
        step();
        ID_MD_start = 0;
        check_eq("div2_busy", MD_busy, 1);
        check_eq("div2_done_lo", MD_done, 0);
        repeat (10) step();
        check_eq("div2_busy_mid", MD_busy, 1);
        // Reset mid-operation
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_busy", MD_busy, 0);
        check_ctl("mid_rst_ctl", 4'b0011);
        check_eq("mid_rst_stall", stall_count, 0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #1;
            check_eq("mid_rst_no_done", {MD_busy, MD_done}, 0);
            step();
        end
        check_eq("post_rst_stall", stall_count, 0);

        // Saturation of the stall counter
        EX_MemRead = 1; EX_rt = 9; ID_rs = 9; ID_uses_rs = 1;
        repeat (65534) @(posedge clk);
        #1;
        check_eq("sat_fffe", stall_count, 32'hFFFE);
        step();
        check_eq("sat_ffff", stall_count, 32'hFFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        check_eq("sat_hold", stall_count, 32'hFFFF);
        clear_inputs();
        step();
        check_eq("sat_release", stall_count, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
